avalon_mailbox_slave: RTL and testbench
=======================================

# avalon_mailbox_slave

Avalon-MM slave mailbox that answers transfers from the JTAG-driven Avalon master (or any Avalon-MM master) on the tester's system interconnect. It gives the host a word-wide bidirectional channel into tester logic:
- a TX FIFO that the host writes and local logic drains;
- an RX FIFO that local logic fills and the host reads;
- status, control, scratch and sticky-error registers, plus a level interrupt.

Every transfer is stretched with a deterministic `waitrequest`, so the master's pending/wait handling is exercised.

## Interface
Parameters:
- data_width, 32, width of Avalon data, FIFO words and scratch register.
- fifo_depth_log2, 4, log2 of each FIFO's depth (depth 16). Legal range 1..7.
- wait_cycles, 1, extra `waitrequest`-high cycles per transfer beyond the first. Legal range 0..15.

Ports:
- avs_mb_clk  in  1  single clock for all logic.
- avs_mb_reset  in  1  asynchronous, active-high reset.
- avs_mb_address  in  3  word address.
- avs_mb_read  in  1  read request.
- avs_mb_write  in  1  write request.
- avs_mb_writedata  in  data_width  write data.
- avs_mb_readdata  out  data_width  read data, registered.
- avs_mb_waitrequest  out  1  slave not ready; master holds request.
- avs_mb_irq  out  1  registered level interrupt.
- coe_tx_data  out  data_width  TX FIFO head (first-word fall-through).
- coe_tx_valid  out  1  equals !tx_empty.
- coe_tx_ready  in  1  local pop strobe, qualified by coe_tx_valid.
- coe_rx_data  in  data_width  local push data.
- coe_rx_valid  in  1  local push strobe.
- coe_rx_ready  out  1  equals !rx_full.

## Operation
Register map (word addresses):
- **0 DATA**
  - Write pushes the TX FIFO. If the TX FIFO is full, the word is dropped and the tx_drop sticky bit is set.
  - Read pops the RX FIFO. If the RX FIFO is empty, readdata=0, nothing is popped, and the rx_underflow sticky bit is set.
- **1 STATUS** (RO)
  - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
  - [4] tx_drop, [5] rx_underflow.
  - [15:8] rx level, zero-extended. [23:16] tx level, zero-extended.
  - All other bits 0. Writes are ignored.
- **2 CONTROL**
  - [0] irq_en, read/write.
  - [1] tx_flush and [2] rx_flush: write-1 pulses, always read 0.
- **3 STICKY_CLR**: write 1 to bit 4 or 5 clears the matching sticky bit. Reads 0.
- **4 SCRATCH**: full-width read/write.
- **5–7**: read 0; writes are ignored.

Transfer state machine (IDLE, BUSY, ACK):
- IDLE, with read|write asserted: go to BUSY with counter=wait_cycles. If wait_cycles=0, go directly to ACK.
- BUSY: decrement counter each cycle. At counter 1, go to ACK.
- ACK: one cycle.
  - Side effects (push, pop, register write, sticky set/clear) execute in this cycle only.
  - readdata is loaded on the edge entering ACK and stays held until the next ACK.
  - Next state is IDLE.
- Request dropped in BUSY (protocol violation): return to IDLE with no side effects.
- read and write both high: treat as a write.

waitrequest = (read|write) && state!=ACK. It is 0 when no request is present.

FIFOs:
- Level counters are fifo_depth_log2+1 bits wide. Pointers wrap modulo depth.
- Simultaneous push and pop at the same FIFO: level unchanged; both operations take effect.
- Push at full is blocked: local side via ready=0, host side via drop.
- A flush and a push/pop in the same cycle: flush wins. The FIFO becomes empty and pointers go to 0.

Interrupt: irq is registered as irq_en && (!rx_empty || tx_drop || rx_underflow).

## Timing
- Reset values:
  - readdata=0, irq=0, waitrequest=0, coe_tx_valid=0, coe_rx_ready=1.
  - Both FIFOs empty; scratch, irq_en and sticky bits 0; FSM in IDLE.
- A transfer presented at cycle 0 sees waitrequest high for wait_cycles+1 cycles. It completes in cycle wait_cycles+1, where waitrequest is low.
- Back-to-back transfers: IDLE follows ACK, so there is at least one waitrequest-high cycle per transfer.
- STATUS read in ACK reflects FIFO state as of the edge entering ACK.
- Local push is visible to the host one cycle later. Host TX push appears on coe_tx_valid the cycle after ACK.
- irq reflects a condition one cycle after the condition appears.
- Reset asserted mid-transfer: immediately return to reset values; the transfer is lost.

## Test plan
- Reset, then with wait_cycles=1 write SCRATCH=0xA5A5_0001 and read it back → waitrequest high for exactly 2 cycles on each transfer; readdata=0xA5A5_0001 in the ACK cycle.
- Write DATA 17 times (values 1..17) with coe_tx_ready=0 → STATUS = tx level 16, tx_full=1, tx_drop=1. Then hold coe_tx_ready=1 → coe_tx_data sequence 1..16, then coe_tx_valid=0.
- Local pushes 0x10..0x1F with irq_en=1 → irq=1 one cycle after the first push; coe_rx_ready=0 after the 16th push. Host reads return 0x10..0x1F; irq=0 after the last pop.
- Read DATA with RX empty → readdata=0, rx_underflow=1. Write STICKY_CLR=0x20 → rx_underflow=0.
- Same cycle as an RX host pop at full: local push succeeds, level stays 16. Write CONTROL=0x6 during a local push → both levels 0.
- Assert reset while in BUSY → waitrequest=0 and readdata=0 immediately. The next transfer completes normally.

Source files
------------

// File: rtl/avalon_mailbox_slave.sv
// Avalon-MM mailbox: host-written TX FIFO, locally-filled RX FIFO, status/control/scratch
// registers and a level interrupt, with every transfer stretched by a fixed waitrequest.
// state | meaning
// IDLE  | no transfer in progress
// BUSY  | counting down waitrequest cycles
// ACK   | transfer completes, side effects applied
module avalon_mailbox_slave #(
  parameter int data_width      = 32,
  parameter int fifo_depth_log2 = 4,
  parameter int wait_cycles     = 1
) (
  input  logic                  avs_mb_clk,
  input  logic                  avs_mb_reset,
  input  logic [2:0]            avs_mb_address,
  input  logic                  avs_mb_read,
  input  logic                  avs_mb_write,
  input  logic [data_width-1:0] avs_mb_writedata,
  output logic [data_width-1:0] avs_mb_readdata,
  output logic                  avs_mb_waitrequest,
  output logic                  avs_mb_irq,
  output logic [data_width-1:0] coe_tx_data,
  output logic                  coe_tx_valid,
  input  logic                  coe_tx_ready,
  input  logic [data_width-1:0] coe_rx_data,
  input  logic                  coe_rx_valid,
  output logic                  coe_rx_ready
);

  localparam int depth = 1 << fifo_depth_log2;
  localparam int aw    = fifo_depth_log2;
  localparam int lw    = fifo_depth_log2 + 1;

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_busy = 2'd1;
  localparam logic [1:0] st_ack  = 2'd2;

  logic [1:0] state;
  logic [3:0] cnt;
  logic       req, enter_ack, in_ack, host_wr, host_rd, rd_pop_q;

  logic [data_width-1:0] tx_mem [depth];
  logic [data_width-1:0] rx_mem [depth];
  logic [aw-1:0]         tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [lw-1:0]         tx_level, rx_level;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
  logic                  wr_data, wr_ctrl, wr_stclr, wr_scratch;

  logic                  irq_en, tx_drop, rx_underflow;
  logic [data_width-1:0] scratch, rd_mux, status;

  assign req       = avs_mb_read | avs_mb_write;
  assign in_ack    = (state == st_ack);
  assign enter_ack = req && (((state == st_idle) && (wait_cycles == 0)) ||
                             ((state == st_busy) && (cnt == 4'd1)));
  assign avs_mb_waitrequest = !avs_mb_reset && req && !in_ack;

  always_ff @(posedge avs_mb_clk or posedge avs_mb_reset) begin
    if (avs_mb_reset) begin
      state <= st_idle;
      cnt   <= '0;
    end else begin
      case (state)
        st_idle: if (req) begin
          if (wait_cycles == 0) state <= st_ack;
          else begin
            state <= st_busy;
            cnt   <= 4'(wait_cycles);
          end
        end
        st_busy: begin
          if (!req) state <= st_idle;
          else if (cnt == 4'd1) state <= st_ack;
          else cnt <= cnt - 4'd1;
        end
        default: state <= st_idle;
      endcase
    end
  end

  assign host_wr    = in_ack && avs_mb_write;
  assign host_rd    = in_ack && avs_mb_read && !avs_mb_write;
  assign wr_data    = host_wr && (avs_mb_address == 3'd0);
  assign wr_ctrl    = host_wr && (avs_mb_address == 3'd2);
  assign wr_stclr   = host_wr && (avs_mb_address == 3'd3);
  assign wr_scratch = host_wr && (avs_mb_address == 3'd4);

  assign tx_full  = (tx_level == lw'(depth));
  assign tx_empty = (tx_level == '0);
  assign rx_full  = (rx_level == lw'(depth));
  assign rx_empty = (rx_level == '0);

  assign tx_push  = wr_data && !tx_full;
  assign tx_pop   = coe_tx_ready && !tx_empty;
  assign tx_flush = wr_ctrl && avs_mb_writedata[1];
  // The pop decision is frozen when readdata is captured, so a word is never popped unseen.
  assign rx_pop   = host_rd && rd_pop_q;
  assign rx_push  = coe_rx_valid && (!rx_full || rx_pop);
  assign rx_flush = wr_ctrl && avs_mb_writedata[2];

  assign coe_tx_data  = tx_mem[tx_rd_ptr];
  assign coe_tx_valid = !tx_empty;
  assign coe_rx_ready = !rx_full;

  always_ff @(posedge avs_mb_clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= avs_mb_writedata;
    if (rx_push) rx_mem[rx_wr_ptr] <= coe_rx_data;
  end

  always_ff @(posedge avs_mb_clk or posedge avs_mb_reset) begin
    if (avs_mb_reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else if (tx_flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_level  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + aw'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + aw'(1);
      if (tx_push && !tx_pop)      tx_level <= tx_level + lw'(1);
      else if (!tx_push && tx_pop) tx_level <= tx_level - lw'(1);
    end
  end

  always_ff @(posedge avs_mb_clk or posedge avs_mb_reset) begin
    if (avs_mb_reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else if (rx_flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_level  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + aw'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + aw'(1);
      if (rx_push && !rx_pop)      rx_level <= rx_level + lw'(1);
      else if (!rx_push && rx_pop) rx_level <= rx_level - lw'(1);
    end
  end

  always_comb begin
    status        = '0;
    status[0]     = tx_full;
    status[1]     = tx_empty;
    status[2]     = rx_full;
    status[3]     = rx_empty;
    status[4]     = tx_drop;
    status[5]     = rx_underflow;
    status[15:8]  = 8'(rx_level);
    status[23:16] = 8'(tx_level);
  end

  always_comb begin
    rd_mux = '0;
    case (avs_mb_address)
      3'd0: rd_mux = rx_empty ? '0 : rx_mem[rx_rd_ptr];
      3'd1: rd_mux = status;
      3'd2: rd_mux[0] = irq_en;
      3'd4: rd_mux = scratch;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge avs_mb_clk or posedge avs_mb_reset) begin
    if (avs_mb_reset) begin
      avs_mb_readdata <= '0;
      rd_pop_q        <= 1'b0;
    end else if (enter_ack) begin
      rd_pop_q <= avs_mb_read && !avs_mb_write && (avs_mb_address == 3'd0) && !rx_empty;
      if (avs_mb_read && !avs_mb_write) avs_mb_readdata <= rd_mux;
    end
  end

  always_ff @(posedge avs_mb_clk or posedge avs_mb_reset) begin
    if (avs_mb_reset) begin
      irq_en       <= 1'b0;
      tx_drop      <= 1'b0;
      rx_underflow <= 1'b0;
      scratch      <= '0;
      avs_mb_irq   <= 1'b0;
    end else begin
      avs_mb_irq <= irq_en && (!rx_empty || tx_drop || rx_underflow);
      if (wr_ctrl)    irq_en  <= avs_mb_writedata[0];
      if (wr_scratch) scratch <= avs_mb_writedata;
      if (wr_data && tx_full) tx_drop <= 1'b1;
      else if (wr_stclr && avs_mb_writedata[4]) tx_drop <= 1'b0;
      if (host_rd && (avs_mb_address == 3'd0) && !rd_pop_q) rx_underflow <= 1'b1;
      else if (wr_stclr && avs_mb_writedata[5]) rx_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_avalon_mailbox_slave.sv
// Self-checking bench for avalon_mailbox_slave: directed scenarios plus randomized
// transfers and local FIFO traffic compared against a queue-based mailbox model.
module tb_avalon_mailbox_slave;
  localparam int DW    = 32;
  localparam int FDL   = 4;
  localparam int WC    = 1;
  localparam int DEPTH = 1 << FDL;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    avs_mb_address;
  logic          avs_mb_read, avs_mb_write;
  logic [DW-1:0] avs_mb_writedata, avs_mb_readdata;
  logic          avs_mb_waitrequest, avs_mb_irq;
  logic [DW-1:0] coe_tx_data, coe_rx_data;
  logic          coe_tx_valid, coe_tx_ready, coe_rx_valid, coe_rx_ready;

  always #5 clk = ~clk;

  avalon_mailbox_slave #(.data_width(DW), .fifo_depth_log2(FDL), .wait_cycles(WC)) dut (
    .avs_mb_clk(clk), .avs_mb_reset(rst),
    .avs_mb_address(avs_mb_address), .avs_mb_read(avs_mb_read), .avs_mb_write(avs_mb_write),
    .avs_mb_writedata(avs_mb_writedata), .avs_mb_readdata(avs_mb_readdata),
    .avs_mb_waitrequest(avs_mb_waitrequest), .avs_mb_irq(avs_mb_irq),
    .coe_tx_data(coe_tx_data), .coe_tx_valid(coe_tx_valid), .coe_tx_ready(coe_tx_ready),
    .coe_rx_data(coe_rx_data), .coe_rx_valid(coe_rx_valid), .coe_rx_ready(coe_rx_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // mailbox model
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic        m_irq_en, m_tx_drop, m_rx_uf, m_irq;
  logic [31:0] m_scratch;
  bit          rnd_local = 0;
  bit          host_ack = 0, host_wr = 0, host_pop_ok = 0;
  logic [2:0]  host_addr = '0;
  logic [31:0] host_wd = '0;

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_irq_en = 0; m_tx_drop = 0; m_rx_uf = 0; m_irq = 0; m_scratch = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [31:0] s;
    s = '0;
    case (a)
      3'd0: s = (rx_q.size() != 0) ? rx_q[0] : 32'h0;
      3'd1: begin
        s[0] = (tx_q.size() == DEPTH);
        s[1] = (tx_q.size() == 0);
        s[2] = (rx_q.size() == DEPTH);
        s[3] = (rx_q.size() == 0);
        s[4] = m_tx_drop;
        s[5] = m_rx_uf;
        s[15:8]  = 8'(rx_q.size());
        s[23:16] = 8'(tx_q.size());
      end
      3'd2: s[0] = m_irq_en;
      3'd4: s = m_scratch;
      default: s = '0;
    endcase
    return s;
  endfunction

  // check this cycle's outputs, advance the model through the coming edge, then step the clock
  task automatic cycle();
    logic irq_next, fl_tx, fl_rx, tx_was_full;
    chk_eq("tx_valid", 32'(coe_tx_valid), 32'(tx_q.size() != 0));
    chk_eq("rx_ready", 32'(coe_rx_ready), 32'(rx_q.size() < DEPTH));
    chk_eq("irq", 32'(avs_mb_irq), 32'(m_irq));
    if (tx_q.size() != 0) chk_eq("tx_data", coe_tx_data, tx_q[0]);
    irq_next = m_irq_en && (rx_q.size() != 0 || m_tx_drop || m_rx_uf);
    tx_was_full = (tx_q.size() == DEPTH);
    fl_tx = 0; fl_rx = 0;
    if (coe_tx_ready && tx_q.size() != 0) void'(tx_q.pop_front());
    if (host_ack && host_wr) begin
      case (host_addr)
        3'd0: if (tx_was_full) m_tx_drop = 1; else tx_q.push_back(host_wd);
        3'd2: begin m_irq_en = host_wd[0]; fl_tx = host_wd[1]; fl_rx = host_wd[2]; end
        3'd3: begin
          if (host_wd[4]) m_tx_drop = 0;
          if (host_wd[5]) m_rx_uf = 0;
        end
        3'd4: m_scratch = host_wd;
        default: ;
      endcase
    end
    if (host_ack && !host_wr && host_addr == 3'd0) begin
      if (host_pop_ok) void'(rx_q.pop_front());
      else m_rx_uf = 1;
    end
    if (coe_rx_valid && rx_q.size() < DEPTH) rx_q.push_back(coe_rx_data);
    if (fl_tx) tx_q.delete();
    if (fl_rx) rx_q.delete();
    m_irq = irq_next;
    @(posedge clk);
    #1;
    if (rnd_local) begin
      coe_tx_ready = ($urandom_range(0, 1) == 1);
      coe_rx_valid = ($urandom_range(0, 2) == 0);
      coe_rx_data  = $urandom;
    end
  endtask

  task automatic host_xfer(input bit wr, input logic [2:0] a, input logic [31:0] wd,
                           output logic [31:0] rd_act);
    int n;
    logic [31:0] exp_rd;
    bit pop_ok;
    n = 0; exp_rd = '0; pop_ok = 0;
    avs_mb_address = a; avs_mb_write = wr; avs_mb_read = !wr; avs_mb_writedata = wd;
    #1;
    while (avs_mb_waitrequest && n < 20) begin
      exp_rd = m_read(a);
      pop_ok = (rx_q.size() != 0);
      n++;
      cycle();
    end
    chk_eq("wait_len", n, WC + 1);
    if (!wr) chk_eq($sformatf("rd_a%0d", a), avs_mb_readdata, exp_rd);
    rd_act = avs_mb_readdata;
    if (n < 20) begin
      host_ack = 1; host_wr = wr; host_addr = a; host_wd = wd; host_pop_ok = pop_ok;
      cycle();
      host_ack = 0;
    end
    avs_mb_read = 0; avs_mb_write = 0;
  endtask

  logic [31:0] r;

  initial begin
    rst = 1; avs_mb_address = 0; avs_mb_read = 0; avs_mb_write = 0; avs_mb_writedata = 0;
    coe_tx_ready = 0; coe_rx_valid = 0; coe_rx_data = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_wait", 32'(avs_mb_waitrequest), 0);
    chk_eq("rst_rdata", avs_mb_readdata, 0);
    chk_eq("rst_irq", 32'(avs_mb_irq), 0);
    chk_eq("rst_txv", 32'(coe_tx_valid), 0);
    chk_eq("rst_rxr", 32'(coe_rx_ready), 1);
    rst = 0;
    cycle();

    // scratch round trip
    host_xfer(1, 3'd4, 32'hA5A5_0001, r);
    host_xfer(0, 3'd4, 0, r);
    chk_eq("scratch", r, 32'hA5A5_0001);

    // TX overfill, then drain
    for (int i = 1; i <= 17; i++) host_xfer(1, 3'd0, i, r);
    host_xfer(0, 3'd1, 0, r);
    chk_eq("tx_lvl16", 32'(r[23:16]), 16);
    chk_eq("tx_full", 32'(r[0]), 1);
    chk_eq("tx_drop", 32'(r[4]), 1);
    coe_tx_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk_eq("tx_seq", coe_tx_data, i + 1);
      cycle();
    end
    chk_eq("tx_drained", 32'(coe_tx_valid), 0);
    coe_tx_ready = 0;
    host_xfer(1, 3'd3, 32'h10, r);

    // RX fill with interrupt, host drain
    host_xfer(1, 3'd2, 32'h1, r);
    cycle();
    for (int i = 0; i < 16; i++) begin
      coe_rx_valid = 1; coe_rx_data = 32'h10 + i;
      cycle();
      if (i == 0) chk_eq("irq_lag", 32'(avs_mb_irq), 0);
      if (i == 1) chk_eq("irq_set", 32'(avs_mb_irq), 1);
    end
    coe_rx_valid = 0;
    chk_eq("rx_full_rdy", 32'(coe_rx_ready), 0);
    for (int i = 0; i < 16; i++) begin
      host_xfer(0, 3'd0, 0, r);
      chk_eq("rx_seq", r, 32'h10 + i);
    end
    cycle();
    chk_eq("irq_clr", 32'(avs_mb_irq), 0);

    // underflow and sticky clear
    host_xfer(0, 3'd0, 0, r);
    chk_eq("uf_rdata", r, 0);
    host_xfer(0, 3'd1, 0, r);
    chk_eq("uf_set", 32'(r[5]), 1);
    host_xfer(1, 3'd3, 32'h20, r);
    host_xfer(0, 3'd1, 0, r);
    chk_eq("uf_clr", 32'(r[5]), 0);

    // push/pop at full RX, then flush during a local push
    for (int i = 0; i < 16; i++) begin
      coe_rx_valid = 1; coe_rx_data = 32'h100 + i;
      cycle();
    end
    coe_rx_data = 32'h99;
    host_xfer(0, 3'd0, 0, r);
    chk_eq("full_pop", r, 32'h100);
    coe_rx_valid = 0;
    host_xfer(0, 3'd1, 0, r);
    chk_eq("full_lvl", 32'(r[15:8]), 16);
    host_xfer(1, 3'd0, 32'h55, r);
    for (int i = 0; i < 4; i++) host_xfer(0, 3'd0, 0, r);
    coe_rx_valid = 1; coe_rx_data = 32'h77;
    host_xfer(1, 3'd2, 32'h6, r);
    coe_rx_valid = 0;
    host_xfer(0, 3'd1, 0, r);
    chk_eq("flush_lvls", 32'(r[23:8]), 0);

    // randomized traffic
    rnd_local = 1;
    for (int k = 0; k < 300; k++) begin
      logic [2:0] a;
      logic [31:0] d;
      bit w;
      a = 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 1) == 1);
      d = $urandom;
      if (a == 3'd2 && $urandom_range(0, 3) != 0) d[2:1] = 2'b00;
      host_xfer(w, a, d, r);
    end
    rnd_local = 0;
    coe_tx_ready = 0; coe_rx_valid = 0;
    cycle();

    // reset in BUSY
    host_xfer(1, 3'd4, 32'h1234, r);
    host_xfer(0, 3'd4, 0, r);
    avs_mb_address = 3'd4; avs_mb_read = 1;
    @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk_eq("rstbusy_wait", 32'(avs_mb_waitrequest), 0);
    chk_eq("rstbusy_rdata", avs_mb_readdata, 0);
    avs_mb_read = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    cycle();
    host_xfer(0, 3'd4, 0, r);
    chk_eq("post_rst_scr", r, 0);
    host_xfer(1, 3'd4, 32'hCAFE_0002, r);
    host_xfer(0, 3'd4, 0, r);
    chk_eq("post_rst_rw", r, 32'hCAFE_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
